// File: rtl/adder_pkg.sv
// adder_pkg: shared mode codes, FSM encoding and CLA helper
// for the adder_engine slice.
package adder_pkg;

    localparam logic [1:0] MODE_RCA = 2'b00;
    localparam logic [1:0] MODE_CLA = 2'b01;
    localparam logic [1:0] MODE_SER = 2'b10;
    localparam logic [1:0] MODE_ILL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SERIAL = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    // Carry into bit k of a 4-bit group, in flat generate/propagate form.
    function automatic logic cla_carry(
        input logic [3:0] p,
        input logic [3:0] g,
        input logic       ci,
        input int         k
    );
        logic c;
        logic t;
        c = 1'b0;
        for (int j = 0; j < 4; j++) begin
            if (j < k) begin
                t = g[j];
                for (int m = j + 1; m < 4; m++)
                    if (m < k) t = t & p[m];
                c = c | t;
            end
        end
        t = ci;
        for (int m = 0; m < 4; m++)
            if (m < k) t = t & p[m];
        return c | t;
    endfunction

endpackage

// File: rtl/adder_engine_if.sv
// adder_engine_if: request and result handshake bundle.
// The engine connects through the slave modport.
interface adder_engine_if #(parameter int WIDTH = 32);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [1:0]       mode;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             err;
    logic [1:0]       out_mode;
    logic             busy;

    modport master (
        output in_valid, a, b, cin, mode, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, err, out_mode, busy
    );

    modport slave (
        input  in_valid, a, b, cin, mode, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, err, out_mode, busy
    );
endinterface

// File: rtl/digit_serial_core.sv
// digit_serial_core: adds DIGIT bits per cycle, LSB first.
// done/sum/cout are valid combinationally in the last digit cycle.
module digit_serial_core
    import adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b_eff,
    input  logic             c0,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             done
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    if (WIDTH % DIGIT != 0) begin : g_bad_digit
        $error("DIGIT must divide WIDTH");
    end

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_s;
    logic             r_c;
    logic [CW-1:0]    r_cnt;
    logic             r_run;
    logic [DIGIT:0]   w_dig;

    assign w_dig = {1'b0, r_a[DIGIT-1:0]}
                 + {1'b0, r_b[DIGIT-1:0]}
                 + {{DIGIT{1'b0}}, r_c};

    // New digit enters at the top; earlier digits shift down.
    assign sum  = (r_s >> DIGIT)
                | (WIDTH'(w_dig[DIGIT-1:0]) << (WIDTH - DIGIT));
    assign cout = w_dig[DIGIT];
    assign done = r_run && (r_cnt == CW'(NDIG - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_s   <= '0;
            r_c   <= 1'b0;
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (start) begin
            r_a   <= a;
            r_b   <= b_eff;
            r_c   <= c0;
            r_cnt <= '0;
            r_run <= 1'b1;
        end else if (r_run) begin
            r_a   <= r_a >> DIGIT;
            r_b   <= r_b >> DIGIT;
            r_s   <= sum;
            r_c   <= w_dig[DIGIT];
            r_cnt <= r_cnt + CW'(1);
            if (done) r_run <= 1'b0;
        end
    end
endmodule

// File: rtl/adder_engine.sv
// adder_engine: handshaked ripple / lookahead / digit-serial adder
// with subtract, signed overflow and illegal-mode flag.
module adder_engine
    import adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    adder_engine_if.slave bus
);
    localparam int MSB = WIDTH - 1;
    localparam int NG  = (WIDTH + 3) / 4;
    localparam int PW  = NG * 4;

    if (WIDTH < 8) begin : g_bad_width
        $error("WIDTH must be at least 8");
    end

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_err;
    logic [1:0]       r_out_mode;
    logic             r_x;

    logic [WIDTH-1:0] w_b_eff;
    logic             w_c0;
    logic             w_ready;
    logic             w_accept;
    logic             w_ill;
    logic             w_start;
    logic             w_ld_comb;
    logic             w_ld_ser;

    assign w_b_eff  = bus.sub ? ~bus.b : bus.b;
    assign w_c0     = bus.sub | bus.cin;
    assign w_ready  = reset_n && ((r_state == ST_IDLE) ||
                      (r_state == ST_HOLD && bus.out_ready));
    assign w_accept = bus.in_valid && w_ready;
    assign w_ill    = (bus.mode == MODE_ILL);

    logic [WIDTH-1:0] w_rs;
    logic             w_rc;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        logic w_ci;
        logic w_co;
        if (i == 0) begin : g_first
            assign w_ci = w_c0;
        end else begin : g_next
            assign w_ci = g_fa[i-1].w_co;
        end
        assign w_rs[i] = bus.a[i] ^ w_b_eff[i] ^ w_ci;
        assign w_co    = (bus.a[i] & w_b_eff[i])
                       | (w_ci & (bus.a[i] ^ w_b_eff[i]));
    end
    assign w_rc = g_fa[WIDTH-1].w_co;

    // Padding bits propagate (p=1, g=0) so the last group carry is cout.
    logic [PW-1:0]    w_pa;
    logic [PW-1:0]    w_pb;
    logic [WIDTH-1:0] w_cs;
    logic             w_cc;

    assign w_pa = ~(PW'(~bus.a));
    assign w_pb = PW'(w_b_eff);

    for (genvar gi = 0; gi < NG; gi++) begin : g_cla
        logic       w_ci;
        logic       w_co;
        logic [3:0] w_p;
        logic [3:0] w_g;
        if (gi == 0) begin : g_first
            assign w_ci = w_c0;
        end else begin : g_next
            assign w_ci = g_cla[gi-1].w_co;
        end
        assign w_p  = w_pa[gi*4 +: 4] ^ w_pb[gi*4 +: 4];
        assign w_g  = w_pa[gi*4 +: 4] & w_pb[gi*4 +: 4];
        assign w_co = cla_carry(w_p, w_g, w_ci, 4);
        for (genvar k = 0; k < 4; k++) begin : g_bit
            if (gi * 4 + k < WIDTH) begin : g_live
                assign w_cs[gi*4+k] = w_p[k]
                                    ^ cla_carry(w_p, w_g, w_ci, k);
            end
        end
    end
    assign w_cc = g_cla[NG-1].w_co;

    logic [WIDTH-1:0] w_csum;
    logic             w_ccout;
    logic             w_covf;

    always_comb begin
        w_csum  = w_rs;
        w_ccout = w_rc;
        unique case (1'b1)
            w_ill: begin
                w_csum  = '0;
                w_ccout = 1'b0;
            end
            (bus.mode == MODE_CLA): begin
                w_csum  = w_cs;
                w_ccout = w_cc;
            end
            default: ;
        endcase
    end

    assign w_covf = !w_ill &&
        (w_ccout ^ bus.a[MSB] ^ w_b_eff[MSB] ^ w_csum[MSB]);

    logic [WIDTH-1:0] w_ssum;
    logic             w_scout;
    logic             w_sdone;

    digit_serial_core #(
        .WIDTH (WIDTH),
        .DIGIT (DIGIT)
    ) u_ser (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (w_start),
        .a       (bus.a),
        .b_eff   (w_b_eff),
        .c0      (w_c0),
        .sum     (w_ssum),
        .cout    (w_scout),
        .done    (w_sdone)
    );

    always_comb begin
        w_next    = r_state;
        w_start   = 1'b0;
        w_ld_comb = 1'b0;
        w_ld_ser  = 1'b0;
        unique case (r_state)
            ST_SERIAL: if (w_sdone) begin
                w_next   = ST_HOLD;
                w_ld_ser = 1'b1;
            end
            ST_HOLD: if (bus.out_ready) w_next = ST_IDLE;
            default: ;
        endcase
        if (w_accept) begin
            if (bus.mode == MODE_SER) begin
                w_next  = ST_SERIAL;
                w_start = 1'b1;
            end else begin
                w_next    = ST_HOLD;
                w_ld_comb = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_sum      <= '0;
            r_cout     <= 1'b0;
            r_ovf      <= 1'b0;
            r_err      <= 1'b0;
            r_out_mode <= MODE_RCA;
            r_x        <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_start) r_x <= bus.a[MSB] ^ w_b_eff[MSB];
            if (w_ld_comb) begin
                r_sum      <= w_csum;
                r_cout     <= w_ccout;
                r_ovf      <= w_covf;
                r_err      <= w_ill;
                r_out_mode <= bus.mode;
            end else if (w_ld_ser) begin
                r_sum      <= w_ssum;
                r_cout     <= w_scout;
                r_ovf      <= w_scout ^ r_x ^ w_ssum[MSB];
                r_err      <= 1'b0;
                r_out_mode <= MODE_SER;
            end
        end
    end

    assign bus.in_ready  = w_ready;
    assign bus.out_valid = (r_state == ST_HOLD);
    assign bus.busy      = (r_state == ST_SERIAL);
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
    assign bus.ovf       = r_ovf;
    assign bus.err       = r_err;
    assign bus.out_mode  = r_out_mode;
endmodule
